nf_uart_receiver: RTL

Serial-to-parallel UART receiver (8N1, LSB first) for the nanoFOX UART peripheral.
- Samples the uart_rx line and recovers one byte per frame.
- Presents each byte through a single-entry holding register with a valid/ack handshake, which the UART register block reads over the bus.
- Bit timing comes from a runtime divider value, e.g. 434 for 115200 baud at 50 MHz.

---
 rtl/nf_uart_pkg.sv | 17 +
 rtl/nf_sync_2ff.sv | 30 +++
 rtl/nf_uart_receiver.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/nf_uart_pkg.sv
// nf_uart_pkg: definitions shared by the nanoFOX UART receiver and transmitter.
//   NF_UART_COMP_W : default width of the bit-period divider / cycle counter
//   NF_UART_DATA_W : default number of data bits per frame
//   rx_state_t     : receiver FSM states
package nf_uart_pkg;

  localparam int NF_UART_COMP_W = 16;
  localparam int NF_UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/nf_sync_2ff.sv
// nf_sync_2ff: two-flop synchronizer for a single asynchronous input bit.
//   clk    : destination clock
//   resetn : asynchronous reset, active-high; both flops load RST_VAL
//   d      : asynchronous input
//   q      : synchronized output (two clk cycles of latency)
module nf_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/nf_uart_receiver.sv
// nf_uart_receiver: 8N1 UART receiver, LSB first, with a single-entry
// holding register read through a valid/ack handshake.
//   clk       : system clock
//   resetn    : asynchronous reset, active-high
//   comp      : bit period in clk cycles (static while rec_en=1, must be >= 2)
//   rec_en    : receiver enable; dropping it aborts a frame in progress
//   uart_rx   : asynchronous serial input, idle high
//   rx_ack    : consumer acknowledge; clears rx_valid and overrun
//   rx_data   : last received byte
//   rx_valid  : holding register full
//   rx_busy   : frame in progress
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   overrun   : sticky, a byte was dropped because rx_valid was still set
module nf_uart_receiver
  import nf_uart_pkg::*;
#(
  parameter int COMP_W = NF_UART_COMP_W,
  parameter int DATA_W = NF_UART_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [COMP_W-1:0] comp,
  input  logic              rec_en,
  input  logic              uart_rx,
  input  logic              rx_ack,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic rx_s;

  rx_state_t          state_q,     state_d;
  logic [COMP_W-1:0]  cnt_q,       cnt_d;
  logic [IDX_W-1:0]   idx_q,       idx_d;
  logic [DATA_W-1:0]  shift_q,     shift_d;
  logic               done_q,      done_d;
  logic               stop_q,      stop_d;
  logic [DATA_W-1:0]  rx_data_q,   rx_data_d;
  logic               rx_valid_q,  rx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q,   overrun_d;

  logic [COMP_W-1:0]  half_m1;
  logic [COMP_W-1:0]  comp_m1;

  nf_sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync_rx (
    .clk    (clk),
    .resetn (resetn),
    .d      (uart_rx),
    .q      (rx_s)
  );

  // The start bit is re-checked at its midpoint; every later sample lands
  // one full bit period after the previous one, i.e. mid-bit.
  assign half_m1 = (comp >> 1) - COMP_W'(1);
  assign comp_m1 = comp - COMP_W'(1);

  // Frame FSM, bit counter and shift register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + COMP_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    stop_d  = stop_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rec_en && (comp >= COMP_W'(2)) && !rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == half_m1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == comp_m1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == LAST_IDX) state_d = STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit lets the next start edge be caught on time.
        if (cnt_q == comp_m1) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          stop_d  = rx_s;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (!rec_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  // Holding register and status flags, updated the cycle after the stop sample
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    if (rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (done_q) begin
      if (!stop_q) begin
        frame_err_d = 1'b1;
      end else if (!rx_valid_q || rx_ack) begin
        // An ack in the same cycle frees the slot, so the new byte is kept.
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      stop_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      stop_q      <= stop_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
